// File: rtl/csa_pkg.sv
// Shared constants for the sequential carry-select adder: state encoding,
// nibble width and a constant clog2 used to size the nibble counter.
package csa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-select adder: two ripple chains (carry-in 0 and 1)
// computed in parallel, the real carry-in only drives the final mux.
module csa_slice4
  import csa_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0]   c0;
  logic [NIB_W:0]   c1;
  logic [NIB_W-1:0] s0;
  logic [NIB_W-1:0] s1;

  assign c0[0] = 1'b0;
  assign c1[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_ripple
      assign s0[gi]   = x[gi] ^ y[gi] ^ c0[gi];
      assign c0[gi+1] = (x[gi] & y[gi]) | (c0[gi] & (x[gi] ^ y[gi]));
      assign s1[gi]   = x[gi] ^ y[gi] ^ c1[gi];
      assign c1[gi+1] = (x[gi] & y[gi]) | (c1[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign s  = ci ? s1 : s0;
  assign co = ci ? c1[NIB_W] : c0[NIB_W];

endmodule

// File: rtl/csa_seq_adder_ctrl.sv
// WIDTH-bit add/subtract done one nibble per cycle through a single
// carry-select slice, with valid/ready handshakes on operands and result.
module csa_seq_adder_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = clog2(NIBS);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;

  logic [NIB_W-1:0] x_nib;
  logic [NIB_W-1:0] y_nib;
  logic [NIB_W-1:0] s_nib;
  logic             co_nib;

  assign x_nib = a_q[nib_cnt_q*NIB_W +: NIB_W];
  assign y_nib = b_q[nib_cnt_q*NIB_W +: NIB_W];

  csa_slice4 u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    nib_cnt_d = nib_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          // Subtraction is a + ~b + 1, so b is inverted once at accept time
          b_d       = b ^ {WIDTH{sub}};
          carry_d   = sub ? 1'b1 : cin;
          nib_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[nib_cnt_q*NIB_W +: NIB_W] = s_nib;
        carry_d = co_nib;
        if (nib_cnt_q == LAST_NIB) begin
          cout_d  = co_nib;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[NIB_W-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          nib_cnt_d = nib_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      nib_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Bench for csa_seq_adder_ctrl: directed vector table, reset abort sequence
// and a random regression against a reference model via a result queue.
module tb_csa_seq_adder_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    int           stall;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  csa_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb     = ms ? ~mb : mb;
    r      = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input int stall, input exp_t e);
    exp_t got;
    int   lat;
    bit   ok;
    sb_q.push_back(e);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      void'(sb_q.pop_back());
      return;
    end
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    ok  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        ok = 1;
        break;
      end
      chk("busy_run", 32'(busy), 32'd1);
      lat++;
    end
    if (!ok) begin
      chk("out_valid_wait", 32'(out_valid), 32'd1);
      void'(sb_q.pop_back());
      return;
    end
    chk("latency", 32'(lat), 32'(W / 4));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      chk("stall_sum", 32'(sum), 32'(sb_q[0].sum));
      chk("stall_cout", 32'(cout), 32'(sb_q[0].cout));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      in_valid = s[0];
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = sb_q.pop_front();
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             ta, tb_v, tc, ts, sum, cout, ovf, lat);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("sum", 32'(sum), 32'(got.sum));
    chk("cout", 32'(cout), 32'(got.cout));
    chk("ovf", 32'(ovf), 32'(got.ovf));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h1235, 1'b1, 1'b1, 0, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{16'h1235, 16'h1234, 1'b0, 1'b1, 2, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 0, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 6, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].stall, e);
    end

    // Abort after the first nibble has been written
    a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_abort_sum", 32'(sum), 32'h0002);
    #1;
    rst_n = 1'b0;
    #1;
    $display("abort sum=%h out_valid=%0d busy=%0d in_ready=%0d", sum, out_valid, busy, in_ready);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e.sum = 16'h0000; e.cout = 1'b1; e.ovf = 1'b0;
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0, e);

    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), model(ra, rb, rc, rs));
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
